alu_sequencer: RTL and testbench

Synchronous front-end that owns the operand/command side of the 32-bit structural ALU. Accepts operation requests over a valid/ready handshake and drives the ALU's `operandA`/`operandB`/`command` inputs from registers. Waits a programmable number of cycles for the gate-level ALU to settle, then captures `result`/`carryout`/`zero`/`overflow` and presents them on a valid/ready response port. Sits between the CPU/testbench control logic and the combinational ALU.

---
 rtl/alu_sequencer.sv | 97 +++++++++
 tb/tb_alu_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready front-end that drives a combinational ALU and captures its settled outputs
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_a,
    input  logic [31:0]          req_b,
    input  logic [2:0]           req_cmd,
    output logic [31:0]          alu_operandA,
    output logic [31:0]          alu_operandB,
    output logic [2:0]           alu_command,
    input  logic [31:0]          alu_result,
    input  logic                 alu_carryout,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_result,
    output logic                 rsp_carryout,
    output logic                 rsp_zero,
    output logic                 rsp_overflow,
    output logic [2:0]           rsp_cmd,
    output logic [CNT_WIDTH-1:0] ops_done
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [31:0]          r_a;
    logic [31:0]          r_b;
    logic [2:0]           r_cmd;
    logic                 r_valid;
    logic [31:0]          r_res;
    logic                 r_c;
    logic                 r_z;
    logic                 r_o;
    logic [2:0]           r_rsp_cmd;
    logic [CNT_WIDTH-1:0] r_ops;
    assign req_ready    = (r_state == IDLE) && !reset;
    assign alu_operandA = r_a;
    assign alu_operandB = r_b;
    assign alu_command  = r_cmd;
    assign rsp_valid    = r_valid;
    assign rsp_result   = r_res;
    assign rsp_carryout = r_c;
    assign rsp_zero     = r_z;
    assign rsp_overflow = r_o;
    assign rsp_cmd      = r_rsp_cmd;
    assign ops_done     = r_ops;
    // Accept, wait for the ALU to settle, capture, then hold the response until it is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cmd     <= '0;
            r_valid   <= 1'b0;
            r_res     <= '0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_o       <= 1'b0;
            r_rsp_cmd <= '0;
            r_ops     <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_a     <= req_a;
                    r_b     <= req_b;
                    r_cmd   <= req_cmd;
                    r_cnt   <= 8'(SETTLE_CYCLES - 1);
                    r_state <= SETTLE;
                end
                SETTLE: if (r_cnt == 8'd0) begin
                    r_res     <= alu_result;
                    r_c       <= alu_carryout;
                    r_z       <= alu_zero;
                    r_o       <= alu_overflow;
                    r_rsp_cmd <= r_cmd;
                    r_valid   <= 1'b1;
                    r_state   <= RESP;
                end else begin
                    r_cnt <= r_cnt - 8'd1;
                end
                RESP: if (rsp_ready) begin
                    r_ops   <= r_ops + CNT_WIDTH'(1);
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench with a behavioural ALU and sequencer model
module tb_alu_sequencer;
    localparam int S = 4;

    int vectors = 0;
    int miscompares = 0;
    int exp_ops = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ALU reference: {carryout, zero, overflow, result}
    function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        logic [32:0] s;
        logic [31:0] r;
        logic c;
        logic o;
        c = 1'b0;
        o = 1'b0;
        s = '0;
        case (cmd)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; o = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32]; o = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: r = a ^ b;
            3'd3: r = {31'd0, $signed(a) < $signed(b)};
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {c, r == 32'd0, o, r};
    endfunction

    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
    logic [31:0] req_a = '0, req_b = '0, alu_a, alu_b, alu_res, rsp_res;
    logic [2:0]  req_cmd = '0, alu_cmd, rsp_cmd;
    logic        alu_c, alu_z, alu_o, rsp_c, rsp_z, rsp_o;
    logic [15:0] ops_done;

    logic        d1_req_valid = 1'b0, d1_req_ready, d1_rsp_valid, d1_rsp_ready = 1'b0;
    logic [31:0] d1_req_a = '0, d1_req_b = '0, d1_alu_a, d1_alu_b, d1_alu_res, d1_rsp_res;
    logic [2:0]  d1_req_cmd = '0, d1_alu_cmd, d1_rsp_cmd;
    logic        d1_alu_c, d1_alu_z, d1_alu_o, d1_rsp_c, d1_rsp_z, d1_rsp_o;
    logic [2:0]  d1_ops_done;

    // Gate-level ALU stand-in: outputs are wrong until operands have been stable long enough
    logic [66:0] last_ops = '0;
    int          stab = 0;
    logic [34:0] alu0_w;
    always @(negedge clk) begin
        if ({alu_a, alu_b, alu_cmd} != last_ops) begin
            last_ops <= {alu_a, alu_b, alu_cmd};
            stab <= 0;
        end else if (stab < 1000) begin
            stab <= stab + 1;
        end
    end
    assign alu0_w = alu_ref(alu_a, alu_b, alu_cmd);
    assign {alu_c, alu_z, alu_o, alu_res} = (stab >= S - 1) ? alu0_w : ~alu0_w;
    assign {d1_alu_c, d1_alu_z, d1_alu_o, d1_alu_res} = alu_ref(d1_alu_a, d1_alu_b, d1_alu_cmd);

    alu_sequencer #(.SETTLE_CYCLES(S), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
        .alu_operandA(alu_a), .alu_operandB(alu_b), .alu_command(alu_cmd),
        .alu_result(alu_res), .alu_carryout(alu_c), .alu_zero(alu_z), .alu_overflow(alu_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_res),
        .rsp_carryout(rsp_c), .rsp_zero(rsp_z), .rsp_overflow(rsp_o), .rsp_cmd(rsp_cmd),
        .ops_done(ops_done)
    );

    alu_sequencer #(.SETTLE_CYCLES(1), .CNT_WIDTH(3)) dut1 (
        .clk(clk), .reset(reset), .req_valid(d1_req_valid), .req_ready(d1_req_ready),
        .req_a(d1_req_a), .req_b(d1_req_b), .req_cmd(d1_req_cmd),
        .alu_operandA(d1_alu_a), .alu_operandB(d1_alu_b), .alu_command(d1_alu_cmd),
        .alu_result(d1_alu_res), .alu_carryout(d1_alu_c), .alu_zero(d1_alu_z), .alu_overflow(d1_alu_o),
        .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_result(d1_rsp_res),
        .rsp_carryout(d1_rsp_c), .rsp_zero(d1_rsp_z), .rsp_overflow(d1_rsp_o), .rsp_cmd(d1_rsp_cmd),
        .ops_done(d1_ops_done)
    );

    // Present a request and return #1 after the edge that accepts it
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        int n = 0;
        req_a = a;
        req_b = b;
        req_cmd = c;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Count edges until rsp_valid is seen, bounded
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_ops++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({req_ready, rsp_valid, alu_a, alu_b, alu_cmd, ops_done, d1_req_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got rdy=%b vld=%b a=%h b=%h cmd=%0d ops=%0d", req_ready, rsp_valid, alu_a, alu_b, alu_cmd, ops_done);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({req_ready, d1_req_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_release_ready got %b%b exp 11", req_ready, d1_req_ready);
        end
    endtask

    task automatic test_add_overflow();
        int lat;
        start_op(32'h7FFFFFFF, 32'h00000001, 3'd0);
        wait_rsp(lat);
        vectors++;
        if (lat !== S) begin miscompares++; $display("FAIL add_latency got %0d exp %0d", lat, S); end
        vectors++;
        if ({rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd} !== {1'b0, 1'b0, 1'b1, 32'h80000000, 3'd0}) begin
            miscompares++;
            $display("FAIL add_overflow got c=%b z=%b o=%b r=%h cmd=%0d exp c=0 z=0 o=1 r=80000000 cmd=0", rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd);
        end
        finish_rsp();
        vectors++;
        if ({rsp_valid, ops_done} !== {1'b0, 16'(exp_ops)}) begin
            miscompares++;
            $display("FAIL add_handshake got vld=%b ops=%0d exp vld=0 ops=%0d", rsp_valid, ops_done, exp_ops);
        end
    endtask

    task automatic test_sub_zero();
        int lat;
        start_op(32'h5, 32'h5, 3'd1);
        wait_rsp(lat);
        vectors++;
        if ({rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd} !== {1'b1, 1'b1, 1'b0, 32'h0, 3'd1}) begin
            miscompares++;
            $display("FAIL sub_zero got c=%b z=%b o=%b r=%h cmd=%0d exp c=1 z=1 o=0 r=0 cmd=1", rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd);
        end
        finish_rsp();
        vectors++;
        if (ops_done !== 16'(exp_ops)) begin miscompares++; $display("FAIL sub_ops got %0d exp %0d", ops_done, exp_ops); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] a, b, na, nb;
        logic [2:0] c, nc;
        logic [37:0] held;
        a = $urandom; b = $urandom; c = 3'($urandom_range(0, 7));
        na = ~a; nb = $urandom; nc = c + 3'd1;
        start_op(a, b, c);
        wait_rsp(lat);
        held = {rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd};
        vectors++;
        if (held !== {alu_ref(a, b, c), c}) begin miscompares++; $display("FAIL bp_result got %h exp %h", held, {alu_ref(a, b, c), c}); end
        req_a = na; req_b = nb; req_cmd = nc; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({rsp_valid, req_ready, rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd} !== {2'b10, held}) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b rsp=%h exp vld=1 rdy=0 rsp=%h", i, rsp_valid, req_ready, {rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd}, held);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_ops++;
        vectors++;
        if ({ops_done, req_ready} !== {16'(exp_ops), 1'b1}) begin
            miscompares++;
            $display("FAIL bp_handshake got ops=%0d rdy=%b exp ops=%0d rdy=1", ops_done, req_ready, exp_ops);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        vectors++;
        if ({alu_a, alu_b, alu_cmd} !== {na, nb, nc}) begin
            miscompares++;
            $display("FAIL bp_next_accept got %h %h %0d exp %h %h %0d", alu_a, alu_b, alu_cmd, na, nb, nc);
        end
        wait_rsp(lat);
        vectors++;
        if ({lat, rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd} !== {S, alu_ref(na, nb, nc), nc}) begin
            miscompares++;
            $display("FAIL bp_next_result got lat=%0d rsp=%h exp lat=%0d rsp=%h", lat, {rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd}, S, {alu_ref(na, nb, nc), nc});
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid_settle();
        bit seen = 1'b0;
        start_op($urandom, $urandom, 3'($urandom_range(1, 7)));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_ops = 0;
        vectors++;
        if ({alu_a, alu_b, alu_cmd, rsp_valid, rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd, ops_done, req_ready} !== '0) begin
            miscompares++;
            $display("FAIL midreset_state got a=%h b=%h cmd=%0d vld=%b r=%h ops=%0d rdy=%b", alu_a, alu_b, alu_cmd, rsp_valid, rsp_res, ops_done, req_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < S + 2; i++) begin
            @(posedge clk); #1;
            seen |= rsp_valid;
            if (i == 0) begin
                vectors++;
                if (req_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready got %b exp 1", req_ready); end
            end
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL midreset_no_rsp got rsp_valid=1 exp 0"); end
    endtask

    task automatic test_input_stability();
        logic [31:0] a, b;
        logic [2:0] c;
        a = $urandom; b = $urandom; c = 3'($urandom_range(0, 7));
        start_op(a, b, c);
        for (int i = 0; i < S + 3; i++) begin
            req_a = $urandom; req_b = $urandom; req_cmd = 3'($urandom);
            @(posedge clk); #1;
            vectors++;
            if ({alu_a, alu_b, alu_cmd} !== {a, b, c}) begin
                miscompares++;
                $display("FAIL stable_operands cycle %0d got %h %h %0d exp %h %h %0d", i, alu_a, alu_b, alu_cmd, a, b, c);
            end
        end
        vectors++;
        if ({rsp_valid, rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd} !== {1'b1, alu_ref(a, b, c), c}) begin
            miscompares++;
            $display("FAIL stable_result got vld=%b rsp=%h exp vld=1 rsp=%h", rsp_valid, {rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd}, {alu_ref(a, b, c), c});
        end
        finish_rsp();
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] a, b;
        logic [2:0] c;
        for (int n = 0; n < 16; n++) begin
            a = $urandom; b = (n % 4 == 0) ? a : $urandom; c = 3'($urandom_range(0, 7));
            if (n % 5 == 1) a = 32'h80000000;
            start_op(a, b, c);
            wait_rsp(lat);
            vectors++;
            if ({lat, rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd} !== {S, alu_ref(a, b, c), c}) begin
                miscompares++;
                $display("FAIL random_op %0d got lat=%0d rsp=%h exp lat=%0d rsp=%h", n, lat, {rsp_c, rsp_z, rsp_o, rsp_res, rsp_cmd}, S, {alu_ref(a, b, c), c});
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            finish_rsp();
            vectors++;
            if (ops_done !== 16'(exp_ops)) begin miscompares++; $display("FAIL random_ops %0d got %0d exp %0d", n, ops_done, exp_ops); end
        end
    endtask

    task automatic test_wrap_throughput();
        logic [66:0] q[$];
        logic [66:0] cur;
        logic [2:0] first_cmds [3];
        int n_acc = 0, n_rsp = 0, cyc = 0, last = -1;
        bit acc, rv;
        first_cmds[0] = 3'd7; first_cmds[1] = 3'd4; first_cmds[2] = 3'd6;
        d1_req_a = $urandom; d1_req_b = $urandom; d1_req_cmd = first_cmds[0];
        d1_req_valid = 1'b1;
        d1_rsp_ready = 1'b1;
        while (n_rsp < 9 && cyc < 60) begin
            acc = d1_req_ready && n_acc < 9;
            if (acc) begin
                q.push_back({d1_req_a, d1_req_b, d1_req_cmd});
                n_acc++;
            end
            rv = d1_rsp_valid;
            if (rv) begin
                cur = q[0];
                vectors++;
                if ({d1_rsp_c, d1_rsp_z, d1_rsp_o, d1_rsp_res, d1_rsp_cmd} !== {alu_ref(cur[66:35], cur[34:3], cur[2:0]), cur[2:0]}) begin
                    miscompares++;
                    $display("FAIL wrap_result %0d got %h exp %h", n_rsp, {d1_rsp_c, d1_rsp_z, d1_rsp_o, d1_rsp_res, d1_rsp_cmd}, {alu_ref(cur[66:35], cur[34:3], cur[2:0]), cur[2:0]});
                end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last !== 3) begin miscompares++; $display("FAIL wrap_period %0d got %0d exp 3", n_rsp, cyc - last); end
                end
                last = cyc;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                d1_req_a = $urandom; d1_req_b = $urandom;
                d1_req_cmd = (n_acc < 3) ? first_cmds[n_acc] : 3'($urandom_range(0, 7));
                if (n_acc == 9) d1_req_valid = 1'b0;
            end
            if (rv) begin
                void'(q.pop_front());
                n_rsp++;
                vectors++;
                if (d1_ops_done !== 3'(n_rsp)) begin miscompares++; $display("FAIL wrap_ops %0d got %0d exp %0d", n_rsp, d1_ops_done, n_rsp % 8); end
            end
        end
        vectors++;
        if (n_rsp !== 9) begin miscompares++; $display("FAIL wrap_timeout got %0d responses exp 9", n_rsp); end
        d1_rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_backpressure();
        test_input_stability();
        test_random();
        test_reset_mid_settle();
        test_wrap_throughput();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
